fp_add_arbiter: RTL
===================

// Module: fp_add_arbiter
// PURPOSE
//  Shares one external fp_add datapath among N requesters, e.g. the CNN accumulate lanes.
//  - Round-robin grant; one operand pair issued per cycle.
//  - Tracks in-flight ops with an ADD_LAT-deep tag pipe.
//  - Returns each sum tagged with its requester id through a result FIFO with credit-based backpressure.
// PARAMETERS
//  N_REQ      4   number of requesters (2..16)
//  ADD_LAT    2   cycles from add_valid issue to add_result valid (>=1, fixed)
//  OUT_DEPTH  4   result FIFO depth; max in-flight + buffered results (power of 2, >=2)
// PORTS
//  clock       in   1          single clock; all state updates on posedge
//  reset_n     in   1          asynchronous, active-low reset
//  req_valid   in   N_REQ      per-requester operand pair valid
//  req_ready   out  N_REQ      per-requester accept; one-hot or zero
//  req_a       in   N_REQ*32   IEEE-754 single operand A, requester i at [32*i+:32]
//  req_b       in   N_REQ*32   operand B, same packing
//  add_a       out  32         operand A to shared adder
//  add_b       out  32         operand B to shared adder
//  add_valid   out  1          issue strobe to adder
//  add_result  in   32         {sign,exponent,mantissa} from adder, valid ADD_LAT cycles after issue
//  res_valid   out  1          result available
//  res_ready   in   1          downstream accept
//  res_data    out  32         sum
//  res_id      out  ID_W       originating requester, ID_W = clog2(N_REQ)
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - rr_ptr=0, tag pipe cleared, FIFO empty, counters 0.
//    - req_ready=0, add_valid=0, res_valid=0, add_a/add_b/res_data/res_id=0.
//  - Credit: occ = inflight_cnt + fifo_cnt, both registered. can_issue = (occ < OUT_DEPTH).
//    - A same-cycle pop does not free credit until the next cycle; no comb path res_ready->req_ready.
//  - Grant: g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//    - issue = |req_valid & can_issue.
//    - req_ready[g] = issue, all others 0. Comb from req_valid; requesters must not wait on ready.
//  - On issue:
//    - add_valid=1; add_a/add_b = req_a/req_b slice g (comb mux).
//    - rr_ptr <= (g+1) mod N_REQ, else rr_ptr holds.
//    - Tag {1,g} enters stage 0 of the tag pipe.
//  - Tag pipe: ADD_LAT-stage shift register of {vld,id}.
//    - When stage ADD_LAT-1 is valid, {add_result,id} is pushed into the FIFO that cycle.
//    - inflight_cnt = +1 on issue, -1 on push; both may happen the same cycle (net 0).
//  - FIFO: first-word-fall-through. res_valid = !empty. Pop on res_valid & res_ready.
//    - Push+pop the same cycle is legal, including when full: push is guaranteed by credit.
//    - Pop on empty is ignored.
//  - Order: results leave in issue order. Per-requester order is preserved.
//  - No arithmetic on data. Sums pass bit-exact; NaN/Inf/denormal handling belongs to the adder.
//  - Reset mid-operation: in-flight tags and buffered results are discarded.
//    - Adder outputs arriving after release are ignored, since no tag is valid.
// CONFIGURATION
//  FP_ARB_STATS_EN defined:
//    - Adds outputs stat_issued[31:0] (issues) and stat_stall[31:0] (cycles with |req_valid && !can_issue).
//    - Both saturate at 32'hFFFF_FFFF and reset to 0.
//  FP_ARB_STATS_EN undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package fp_arb_pkg:
//    - FP_W=32.
//    - typedef fp_word_t [31:0].
//    - typedef struct tag_t {vld, id}.
//    - function clog2 for ID_W.
//  - Sub-module fp_arb_res_fifo:
//    - Parameterised DEPTH x (32+ID_W).
//    - Ports: push, pop, din, dout, empty, full, count.
//  - Arbiter, credit logic and tag pipe stay in this module.
// TESTING
//  - Single op: requester 2 sends 0x3F800000 + 0x40000000 (1.0+2.0).
//    -> add_valid once; 0x40400000 res_id=2 at issue+ADD_LAT+1 cycles.
//  - Fairness: N_REQ=4, all valid constantly, res_ready=1 -> grant order 0,1,2,3,0,1,... with no gaps.
//  - Backpressure: res_ready=0, OUT_DEPTH=4, all valid.
//    -> exactly 4 issues, then req_ready=0 indefinitely.
//    -> Raising res_ready for one cycle allows exactly 1 issue, starting the following cycle.
//  - Simultaneous: full FIFO with pop and push in the same cycle -> count stays 4, data order intact, no loss.
//  - Reset mid-op: 3 ops in flight, pulse reset_n low for 1 cycle.
//    -> res_valid=0 after release; no stale results emerge; next grant goes to requester 0 first.
//  - Stats (FP_ARB_STATS_EN): 10 issues plus 5 credit-stall cycles -> stat_issued=10, stat_stall=5.

Source files
------------

// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the fp_add arbiter slice.
// Contents: FP_W word width, fp_word_t, tag_t {vld, id}, clog2() for ID/count widths.
// ID_MAX_W covers the largest supported requester count (16).
package fp_arb_pkg;

  localparam int FP_W     = 32;
  localparam int ID_MAX_W = 4;

  typedef logic [FP_W-1:0] fp_word_t;

  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  // Bits needed to encode values 0..v-1 (v >= 1).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_arb_res_fifo.sv
// Purpose: first-word-fall-through result FIFO, DEPTH x W, async active-low reset.
// Latency: a push is visible on dout the cycle after; dout is zero while empty.
// Backpressure: pop on empty is ignored; push while full is accepted only with a same-cycle pop.
// Ports: clock, reset_n, push, pop, din, dout, empty, full, count.
module fp_arb_res_fifo
  import fp_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 34,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  // When full, the slot under wptr is the one being read out this cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Purpose: round-robin sharing of one external fp_add among N_REQ requesters; sums return tagged with requester id.
// Latency: grant/issue combinational; result on res_* ADD_LAT+1 cycles after issue.
// Backpressure: credit = in-flight + buffered < OUT_DEPTH; a pop frees credit only from the next cycle.
// Ports: clock/reset_n; req_valid/req_ready/req_a/req_b (requesters); add_a/add_b/add_valid/add_result
//        (shared adder); res_valid/res_ready/res_data/res_id (results).
// Optional: FP_ARB_STATS_EN adds stat_issued/stat_stall saturating counters.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADD_LAT   = 2,
  parameter int OUT_DEPTH = 4,
  localparam int ID_W     = clog2(N_REQ)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*FP_W-1:0] req_a,
  input  logic [N_REQ*FP_W-1:0] req_b,
  output logic [FP_W-1:0]       add_a,
  output logic [FP_W-1:0]       add_b,
  output logic                  add_valid,
  input  logic [FP_W-1:0]       add_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [FP_W-1:0]       res_data,
  output logic [ID_W-1:0]       res_id
`ifdef FP_ARB_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stall
`endif
);

  localparam int CNT_W = clog2(OUT_DEPTH) + 1;
  localparam int RES_W = FP_W + ID_W;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(OUT_DEPTH);

  logic              run_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   rr_ptr_d;
  logic [ID_W-1:0]   grant_id;
  logic              grant_found;
  logic              can_issue;
  logic              issue;
  logic [CNT_W-1:0]  inflight_q;
  logic [CNT_W-1:0]  inflight_d;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    occ;
  tag_t              tag_q [ADD_LAT];
  logic              fifo_push;
  logic              fifo_empty;
  logic              fifo_full;
  logic [RES_W-1:0]  fifo_din;
  logic [RES_W-1:0]  fifo_dout;
  logic              unused_tag_bits;

  // Credit: both terms registered, so res_ready has no path to req_ready.
  // fifo_full is implied by the credit check and only acts as a guard.
  assign occ       = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign can_issue = (occ < DEPTH_L) && !fifo_full;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // run_q holds issue off while reset is asserted and for the release cycle,
  // so req_ready/add_valid stay low even if requesters are already valid.
  assign issue     = run_q & grant_found & can_issue;
  assign add_valid = issue;

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (issue) begin
      req_ready[grant_id] = 1'b1;
      add_a = req_a[FP_W*grant_id +: FP_W];
      add_b = req_b[FP_W*grant_id +: FP_W];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag pipe tail lines up with add_result; every valid tail becomes a FIFO push.
  assign fifo_push       = tag_q[ADD_LAT-1].vld;
  assign fifo_din        = {add_result, tag_q[ADD_LAT-1].id[ID_W-1:0]};
  assign unused_tag_bits = ^tag_q[ADD_LAT-1].id;

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, fifo_push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      for (int s = 0; s < ADD_LAT; s++) tag_q[s] <= '0;
    end else begin
      run_q      <= 1'b1;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      tag_q[0]   <= issue ? tag_t'{vld: 1'b1, id: ID_MAX_W'(grant_id)} : '0;
      for (int s = 1; s < ADD_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  fp_arb_res_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (RES_W)
  ) u_res_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (res_ready),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_cnt)
  );

  assign res_valid = ~fifo_empty;
  assign res_data  = fifo_dout[RES_W-1:ID_W];
  assign res_id    = fifo_dout[ID_W-1:0];

`ifdef FP_ARB_STATS_EN
  logic [31:0] stat_issued_q;
  logic [31:0] stat_stall_q;
  logic        stall;

  assign stall = (|req_valid) & ~can_issue;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (issue && (stat_issued_q != 32'hFFFF_FFFF)) stat_issued_q <= stat_issued_q + 1'b1;
      if (stall && (stat_stall_q  != 32'hFFFF_FFFF)) stat_stall_q  <= stat_stall_q + 1'b1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule
